// File: rtl/sprite_fetch_pkg.sv
// Shared types and helpers for the sprite ROM fetch unit:
// swizzle mode encodings, fetch FSM states and the address swizzle helpers.
package sprite_fetch_pkg;

  typedef enum logic [1:0] {
    SWZ_LINEAR = 2'd0,  // {bank, ca}
    SWZ_NIBBLE = 2'd1,  // low 6 address bits permuted
    SWZ_BYTE   = 2'd2,  // low 8 address bits permuted
    SWZ_AUTO   = 2'd3   // nibble layout for the top ROM region, byte layout elsewhere
  } swz_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_e;

  // Resolve the automatic mode from the top four character-address bits.
  function automatic swz_mode_e resolve_mode(input swz_mode_e mode, input logic [3:0] ca_top);
    if (mode != SWZ_AUTO) return mode;
    return (ca_top == 4'hF) ? SWZ_NIBBLE : SWZ_BYTE;
  endfunction

  // Permute the low byte of the character address; upper bits pass through
  // unchanged in every mode, so only the low byte needs handling here.
  function automatic logic [7:0] swizzle_lo(input swz_mode_e mode, input logic [7:0] lo);
    case (mode)
      SWZ_NIBBLE: swizzle_lo = {lo[7:6], lo[4], lo[2], lo[1:0], lo[5], lo[3]};
      SWZ_BYTE:   swizzle_lo = {lo[6], lo[4], lo[2], lo[1:0], lo[7], lo[5], lo[3]};
      default:    swizzle_lo = lo;
    endcase
  endfunction

endpackage

// File: rtl/sprite_rsp_fifo.sv
// Per-channel response FIFO: DEPTH x DW, first-word-fall-through head,
// occupancy output and synchronous clear. Head reads as zero when empty.
module sprite_rsp_fifo
  import sprite_fetch_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nRES,
  input  logic                       clr,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       valid,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [OW-1:0] occ_reg;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign valid   = (occ_reg != '0);
  assign full    = (occ_reg == OW'(DEPTH));
  assign do_pop  = pop && valid;
  // A push into a full FIFO is only accepted when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  assign head      = valid ? mem[rd_ptr_reg] : '0;
  assign occupancy = occ_reg;

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      occ_reg <= occ_reg + OW'(do_push) - OW'(do_pop);
    end
  end

  // Storage write; contents need no reset because the head is gated by valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/sprite_rom_fetch.sv
// Sprite graphics-ROM fetch unit: round-robin arbitration of per-channel
// character-address requests, selectable address swizzle, single outstanding
// req/ack ROM transaction, chunky-to-planar conversion into per-channel FIFOs.
module sprite_rom_fetch
  import sprite_fetch_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int AW       = 18,
  parameter int DW       = 32,
  parameter int PLANES   = 4,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   nRES,
  input  logic [1:0]             mode,
  input  logic                   flush,
  input  logic [CHANNELS-1:0]    req_valid,
  input  logic [CHANNELS*AW-1:0] req_ca,
  input  logic [CHANNELS-1:0]    req_bank,
  output logic [CHANNELS-1:0]    req_ready,
  output logic [CHANNELS-1:0]    rsp_valid,
  output logic [CHANNELS*DW-1:0] rsp_data,
  input  logic [CHANNELS-1:0]    rsp_ready,
  output logic                   rom_req,
  output logic [AW:0]            rom_addr,
  input  logic                   rom_ack,
  input  logic [DW-1:0]          rom_dout
);

  localparam int PX = DW / PLANES;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OW = $clog2(DEPTH) + 1;

  fetch_state_e      state_reg, state_next;
  logic              rom_req_reg, rom_req_next;
  logic [AW:0]       rom_addr_reg, rom_addr_next;
  logic [CW-1:0]     grant_reg, grant_next;
  logic [CW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic              discard_reg, discard_next;
  logic              ready_en_reg;

  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] inflight;
  logic [OW-1:0]       occ [CHANNELS];
  logic [DW-1:0]       planar;

  logic              grant_found;
  logic [CW-1:0]     sel;
  int                idx;
  logic [AW-1:0]     sel_ca;
  swz_mode_e         eff_mode;
  logic [AW:0]       swz_addr;

  assign rom_req  = rom_req_reg;
  assign rom_addr = rom_addr_reg;
  assign eligible = req_valid & req_ready;

  // Chunky-to-planar: bit j of plane p comes from chunky bit PLANES*j + p.
  for (genvar gi = 0; gi < PLANES; gi++) begin : g_plane
    for (genvar gj = 0; gj < PX; gj++) begin : g_bit
      assign planar[gi*PX + gj] = rom_dout[PLANES*gj + gi];
    end
  end

  // Per-channel credit check and response FIFO; the in-flight slot is
  // reserved so an accepted request always has room to land.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign inflight[gi]  = (state_reg == ST_BUSY) && (grant_reg == CW'(gi)) && !discard_reg;
    assign req_ready[gi] = ready_en_reg && (state_reg == ST_IDLE) &&
                           (({1'b0, occ[gi]} + (OW+1)'(inflight[gi])) < (OW+1)'(DEPTH));

    sprite_rsp_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .nRES      (nRES),
      .clr       (flush),
      .push      (push[gi]),
      .push_data (planar),
      .pop       (rsp_ready[gi]),
      .valid     (rsp_valid[gi]),
      .head      (rsp_data[gi*DW +: DW]),
      .occupancy (occ[gi])
    );
  end

  // Round-robin pick: search starts at the channel after the last grant.
  always_comb begin
    grant_found = 1'b0;
    sel         = '0;
    idx         = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(rr_ptr_reg) + i) % CHANNELS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        sel         = CW'(idx);
      end
    end
  end

  // Swizzle the selected channel's address with the mode present at acceptance.
  always_comb begin
    sel_ca        = req_ca[sel*AW +: AW];
    eff_mode      = resolve_mode(swz_mode_e'(mode), sel_ca[AW-1:AW-4]);
    swz_addr      = {1'b0, sel_ca};
    swz_addr[7:0] = swizzle_lo(eff_mode, sel_ca[7:0]);
    if (eff_mode == SWZ_LINEAR) swz_addr[AW] = req_bank[sel];
  end

  // Next-state and datapath updates for the IDLE/BUSY handshake.
  always_comb begin
    state_next    = state_reg;
    rom_req_next  = rom_req_reg;
    rom_addr_next = rom_addr_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    discard_next  = discard_reg;
    push          = '0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_found) begin
          state_next    = ST_BUSY;
          rom_req_next  = 1'b1;
          rom_addr_next = swz_addr;
          grant_next    = sel;
          rr_ptr_next   = (sel == CW'(CHANNELS-1)) ? '0 : sel + 1'b1;
          discard_next  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (flush) discard_next = 1'b1;
        if (rom_ack) begin
          if (!discard_reg && !flush) push[grant_reg] = 1'b1;
          rom_req_next = 1'b0;
          discard_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Transaction registers: ROM request/address, grant owner, RR pointer, discard flag.
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      rom_req_reg  <= 1'b0;
      rom_addr_reg <= '0;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      discard_reg  <= 1'b0;
    end else begin
      rom_req_reg  <= rom_req_next;
      rom_addr_reg <= rom_addr_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      discard_reg  <= discard_next;
    end
  end

  // Hold req_ready low through reset and release it on the first clock after.
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) ready_en_reg <= 1'b0;
    else       ready_en_reg <= 1'b1;
  end

endmodule

// File: tb/tb_sprite_rom_fetch.sv
// Directed bench for sprite_rom_fetch with hand-computed expected values.
module tb_sprite_rom_fetch;

  logic        clk = 1'b0;
  logic        nRES;
  logic [1:0]  mode;
  logic        flush;
  logic [1:0]  req_valid;
  logic [35:0] req_ca;
  logic [1:0]  req_bank;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_ready;
  logic        rom_req;
  logic [18:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_dout;

  int checks = 0;
  int errors = 0;
  int acks;

  sprite_rom_fetch #(
    .CHANNELS (2),
    .AW       (18),
    .DW       (32),
    .PLANES   (4),
    .DEPTH    (4)
  ) dut (
    .clk       (clk),
    .nRES      (nRES),
    .mode      (mode),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ca    (req_ca),
    .req_bank  (req_bank),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .rom_req   (rom_req),
    .rom_addr  (rom_addr),
    .rom_ack   (rom_ack),
    .rom_dout  (rom_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rom_req(input string tag);
    int n = 0;
    while (!rom_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 64'(rom_req), 64'd1);
  endtask

  // One full transaction on a single channel, checked end to end.
  task automatic do_txn(input int ch, input logic [17:0] ca, input logic bank,
                        input logic [1:0] md, input logic [31:0] dout,
                        input logic [18:0] exp_addr, input logic [31:0] exp_data,
                        input string tag);
    @(negedge clk);
    req_valid[ch] = 1'b1;
    req_ca[ch*18 +: 18] = ca;
    req_bank[ch] = bank;
    mode = md;
    @(negedge clk);
    wait_rom_req(tag);
    req_valid[ch] = 1'b0;
    chk({tag, "_addr"}, 64'(rom_addr), 64'(exp_addr));
    @(negedge clk);
    @(negedge clk);
    rom_ack = 1'b1;
    rom_dout = dout;
    @(negedge clk);
    rom_ack = 1'b0;
    rom_dout = '0;
    chk({tag, "_req_low"}, 64'(rom_req), 64'd0);
    chk({tag, "_valid"}, 64'(rsp_valid[ch]), 64'd1);
    chk({tag, "_data"}, 64'(rsp_data[ch*32 +: 32]), 64'(exp_data));
    rsp_ready[ch] = 1'b1;
    @(negedge clk);
    rsp_ready[ch] = 1'b0;
    chk({tag, "_popped"}, 64'(rsp_valid[ch]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRES = 1'b0; mode = '0; flush = 1'b0; req_valid = '0; req_ca = '0;
    req_bank = '0; rsp_ready = '0; rom_ack = 1'b0; rom_dout = '0;

    // Reset state.
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rom_req", 64'(rom_req), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    @(negedge clk);
    nRES = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd3);

    // Swizzle modes and planar conversion.
    do_txn(0, 18'h3FFC0, 1'b0, 2'd3, 32'h0000_0001, 19'h3FFC0, 32'h0000_0001, "auto_top");
    do_txn(1, 18'h00012, 1'b1, 2'd0, 32'h8765_4321, 19'h40012, 32'h8078_6655, "linear_bank");
    do_txn(0, 18'h0001F, 1'b1, 2'd1, 32'h0000_000F, 19'h0003D, 32'h0101_0101, "nibble");
    do_txn(1, 18'h1235A, 1'b0, 2'd2, 32'hFFFF_FFFF, 19'h123D1, 32'hFFFF_FFFF, "byte");
    do_txn(0, 18'h00080, 1'b0, 2'd3, 32'h0000_0010, 19'h00004, 32'h0000_0002, "auto_low");
    do_txn(1, 18'h3C020, 1'b1, 2'd3, 32'h0000_0002, 19'h3C002, 32'h0000_0100, "auto_nib");

    // Round robin with both channels requesting continuously.
    @(negedge clk);
    mode = 2'd0; req_bank = '0;
    req_ca = {18'h00200, 18'h00100};
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wait_rom_req("rr");
      chk("rr_grant", 64'(rom_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
      rom_ack = 1'b1;
      rom_dout = 32'h0;
      @(negedge clk);
      rom_ack = 1'b0;
      if (k == 3) req_valid = 2'b00;
    end
    @(negedge clk);
    rsp_ready = 2'b00;
    @(negedge clk);

    // Back-pressure: ch0 never pops, so exactly DEPTH requests fit.
    req_ca[17:0] = 18'h00300;
    req_valid[0] = 1'b1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rom_ack) begin
        rom_ack = 1'b0;
      end else if (rom_req) begin
        rom_ack = 1'b1;
        rom_dout = 32'h0000_0001;
        acks++;
      end
    end
    rom_ack = 1'b0;
    chk("bp_accepts", 64'(acks), 64'd4);
    chk("bp_ready", 64'(req_ready), 64'd2);
    chk("bp_valid", 64'(rsp_valid), 64'd1);
    chk("bp_head", 64'(rsp_data[31:0]), 64'd1);
    do_txn(1, 18'h00055, 1'b0, 2'd0, 32'h0000_0100, 19'h00055, 32'h0000_0004, "bp_ch1");
    chk("bp_ch0_still_full", 64'(req_ready[0]), 64'd0);
    req_valid[0] = 1'b0;

    // Flush in IDLE empties the full FIFO.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_valid", 64'(rsp_valid), 64'd0);
    chk("flush_idle_ready", 64'(req_ready), 64'd3);

    // Flush while BUSY: handshake completes, data dropped.
    @(negedge clk);
    req_ca[17:0] = 18'h00400;
    mode = 2'd0;
    req_valid[0] = 1'b1;
    @(negedge clk);
    wait_rom_req("flush_busy");
    req_valid[0] = 1'b0;
    chk("flush_busy_addr", 64'(rom_addr), 64'h400);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    rom_ack = 1'b1;
    rom_dout = 32'hFFFF_FFFF;
    @(negedge clk);
    rom_ack = 1'b0;
    chk("flush_busy_dropped", 64'(rsp_valid), 64'd0);
    chk("flush_busy_req_low", 64'(rom_req), 64'd0);
    chk("flush_busy_ready", 64'(req_ready), 64'd3);
    do_txn(0, 18'h00001, 1'b0, 2'd1, 32'h0000_0004, 19'h00004, 32'h0001_0000, "after_flush");

    // Reset in the middle of a transaction, then a stray acknowledge.
    @(negedge clk);
    req_ca[35:18] = 18'h00777;
    mode = 2'd0;
    req_valid[1] = 1'b1;
    @(negedge clk);
    wait_rom_req("mid_rst");
    req_valid[1] = 1'b0;
    #2;
    nRES = 1'b0;
    #1;
    chk("mid_rst_req", 64'(rom_req), 64'd0);
    chk("mid_rst_addr", 64'(rom_addr), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    nRES = 1'b1;
    rom_ack = 1'b1;
    rom_dout = 32'hFFFF_FFFF;
    @(negedge clk);
    rom_ack = 1'b0;
    chk("stray_ack_valid", 64'(rsp_valid), 64'd0);
    chk("stray_ack_req", 64'(rom_req), 64'd0);
    chk("stray_ack_ready", 64'(req_ready), 64'd3);
    do_txn(0, 18'h00012, 1'b1, 2'd0, 32'h8765_4321, 19'h40012, 32'h8078_6655, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_fetch.md
# sprite_rom_fetch

Parametrised sprite graphics-ROM fetch unit sitting between one or more K051960-class sprite address generators and the shared SDRAM sprite-ROM port. It arbitrates per-channel character-address requests, applies a run-time-selectable board address swizzle, runs a req/ack handshake to the ROM, and returns chunky-to-planar converted words through per-channel response FIFOs. It supersedes the fixed single-channel wiring in the sprite layer and supports multi-chip boards and per-game ROM layouts without RTL edits.

## Interface
- CHANNELS, 2, number of independent requesters (1..4)
- AW, 18, character address width (min 8)
- DW, 32, ROM data word width
- PLANES, 4, bitplanes; DW must be a multiple of PLANES
- DEPTH, 4, response FIFO entries per channel (power of two, min 2)

- clk  in  1  system clock, all logic on rising edge
- nRES  in  1  asynchronous active-low reset
- mode  in  2  address swizzle select, sampled at request acceptance
- flush  in  1  synchronous: empty all FIFOs, discard in-flight data
- req_valid  in  CHANNELS  request strobe per channel
- req_ca  in  CHANNELS*AW  character address per channel
- req_bank  in  CHANNELS  bank bit per channel (used in mode 0 only)
- req_ready  out  CHANNELS  channel can accept a request this cycle
- rsp_valid  out  CHANNELS  FIFO head valid
- rsp_data  out  CHANNELS*DW  planar word at FIFO head
- rsp_ready  in  CHANNELS  consumer pops head
- rom_req  out  1  ROM request, held until acknowledged
- rom_addr  out  AW+1  ROM word address, stable while rom_req high
- rom_ack  in  1  one-cycle pulse, rom_dout valid same cycle
- rom_dout  in  DW  chunky ROM data

## Operation
- States: IDLE, BUSY. One outstanding ROM transaction total.
- IDLE: round-robin grant among channels with req_valid & req_ready, starting after last granted channel; grant latches swizzled address, channel id; rom_req<=1; -> BUSY.
- BUSY: on rom_ack, convert rom_dout and push to granted channel FIFO (unless discard flag set); rom_req<=0; -> IDLE.
- req_ready[c] = (state==IDLE) & (occupancy[c] + inflight[c] < DEPTH); never high when FIFO full counting in-flight slot.
- Swizzle (ca = latched CA): mode 0 {bank, ca}; mode 1 {0, ca[AW-1:6], ca[4], ca[2], ca[1:0], ca[5], ca[3]}; mode 2 {0, ca[AW-1:8], ca[6], ca[4], ca[2], ca[1:0], ca[7], ca[5], ca[3]}; mode 3 = mode 1 if ca[AW-1:AW-4] all ones, else mode 2.
- Planar: PX=DW/PLANES; plane p occupies rsp_data[p*PX +: PX]; bit j of plane p = rom_dout[PLANES*j + p].
- flush: FIFOs cleared same edge; if BUSY, discard flag set, transaction still completes handshake, data dropped; flush during a grant cycle cancels nothing already issued.
- Simultaneous push and pop on a channel: occupancy unchanged, both honoured, legal when full.

## Timing
- Reset values: rom_req 0, rom_addr 0, req_ready all 0 during reset, all 1 first cycle after, rsp_valid 0, rsp_data 0, RR pointer channel 0, state IDLE.
- Acceptance at edge N -> rom_req high after edge N. rom_ack at edge M -> rsp_valid high after edge M. Minimum request-to-response latency 2 cycles plus ROM latency; max throughput one word per 2 cycles.
- rom_ack while IDLE ignored (covers reset mid-transaction).
- Reset mid-operation: asynchronous clear of all state; rom_req drops immediately.

## Structure
- Package sprite_fetch_pkg: mode encodings (SWZ_LINEAR, SWZ_NIBBLE, SWZ_BYTE, SWZ_AUTO), state enum, swizzle function.
- One sub-module: sprite_rsp_fifo (DEPTH x DW, occupancy output, sync clear), instantiated per channel.

## Test plan
- Reset, CHANNELS=2: ch0 req ca=0x3FFC0 mode 3, ROM ack after 3 cycles with 0x00000001 -> rom_addr 0x3FFC0 via mode 1 mapping, rsp_data[0] plane0 bit0 =1, all else 0.
- Both channels request continuously -> grants alternate 0,1,0,1; no channel starved.
- ch0 rsp_ready=0, DEPTH=4 -> exactly 4 accepts, req_ready[0]=0 thereafter, ch1 unaffected.
- rom_dout=0x87654321 mode 0 bank=1 ca=0x00012 -> rom_addr 0x40012, planar reformatting matches bit-rule per plane.
- flush while BUSY -> ack completes, rsp_valid stays 0, next request served normally.
- nRES low mid-BUSY then release; stray rom_ack -> ignored, no rsp_valid.
